// File: rtl/mem_write_monitor.sv
// Watches a processor's data-write port and latches a PASS/FAIL/TIMEOUT verdict.
// Define MEM_MON_WINDOW_EN to accept any write in [ALLOW_LO, ALLOW_HI] instead of only IGNORE_ADDR.
module mem_write_monitor #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned PASS_ADDR      = 100,
    parameter int unsigned PASS_DATA      = 7,
    parameter int unsigned IGNORE_ADDR    = 96,
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 8
`ifdef MEM_MON_WINDOW_EN
    ,
    parameter int unsigned ALLOW_LO       = 0,
    parameter int unsigned ALLOW_HI       = 252
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  write_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int unsigned     CYC_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } state_t;

    state_t             state, state_n;
    logic [CYC_W-1:0]   cyc, cyc_n;
    logic [CNT_W-1:0]   wc_n;
    logic [ADDR_W-1:0]  fa_n;
    logic [DATA_W-1:0]  fd_n;

    logic wr_x;
    logic wr;
    logic hit_pass_addr;
    logic legal;
    logic is_pass;
    logic is_fail;
    logic expire;

    // An unknown strobe compares unequal to both 0 and 1; in hardware this reduces to 0.
    assign wr_x          = (MemWrite !== 1'b0) && (MemWrite !== 1'b1);
    assign wr            = (MemWrite == 1'b1) || wr_x;
    assign hit_pass_addr = (DataAdr == ADDR_W'(PASS_ADDR));
    assign is_pass       = wr && !wr_x && hit_pass_addr && (WriteData == DATA_W'(PASS_DATA));

`ifdef MEM_MON_WINDOW_EN
    assign legal = (DataAdr >= ADDR_W'(ALLOW_LO)) && (DataAdr <= ADDR_W'(ALLOW_HI)) && !hit_pass_addr;
`else
    assign legal = (DataAdr == ADDR_W'(IGNORE_ADDR)) && !hit_pass_addr;
`endif

    assign is_fail = wr && (wr_x || !(is_pass || legal));
    assign expire  = (cyc == CYC_LAST);

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        wc_n    = write_count;
        fa_n    = fail_addr;
        fd_n    = fail_data;
        if (clear) begin
            state_n = RUN;
            cyc_n   = '0;
            wc_n    = '0;
            fa_n    = '0;
            fd_n    = '0;
        end else if (state == RUN) begin
            cyc_n = cyc + CYC_W'(1);
            if (wr && (write_count != '1)) begin
                wc_n = write_count + CNT_W'(1);
            end
            // A terminating write outranks expiry on the same edge.
            if (is_pass) begin
                state_n = PASS;
            end else if (is_fail) begin
                state_n = FAIL;
                fa_n    = DataAdr;
                fd_n    = WriteData;
            end else if (expire) begin
                state_n = TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cyc         <= '0;
            write_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            write_count <= wc_n;
            fail_addr   <= fa_n;
            fail_data   <= fd_n;
            done        <= (state_n != RUN);
            pass        <= (state_n == PASS);
            fail        <= (state_n == FAIL);
            timeout     <= (state_n == TIMEOUT);
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed self-checking bench for mem_write_monitor (default build, window feature off).
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        done, pass, fail, timeout;
    logic [7:0]  write_count;
    logic [31:0] fail_addr, fail_data;

    logic        s_done, s_pass, s_fail, s_timeout;
    logic [1:0]  s_write_count;
    logic [31:0] s_fail_addr, s_fail_data;

    int checks = 0;
    int errors = 0;

    mem_write_monitor dut (
        .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .write_count(write_count), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    // Narrow counter copy, used only to observe saturation.
    mem_write_monitor #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
        .write_count(s_write_count), .fail_addr(s_fail_addr), .fail_data(s_fail_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic d, input logic p,
                               input logic f, input logic t);
        check({tag, ".done"},    32'(done),    32'(d));
        check({tag, ".pass"},    32'(pass),    32'(p));
        check({tag, ".fail"},    32'(fail),    32'(f));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        #12;
        check_flags("rst", 0, 0, 0, 0);
        check("rst.wc", 32'(write_count), 0);
        check("rst.fa", fail_addr, 0);
        check("rst.fd", fail_data, 0);
        reset = 1'b1;

        // legal write then expected write
        wr(96, 123);
        check_flags("ign", 0, 0, 0, 0);
        check("ign.wc", 32'(write_count), 1);
        wr(100, 7);
        check_flags("pass", 1, 1, 0, 0);
        check("pass.wc", 32'(write_count), 2);
        tick();
        check_flags("pass.sticky", 1, 1, 0, 0);

        // clear beats a concurrent illegal write
        clear = 1'b1; MemWrite = 1'b1; DataAdr = 50; WriteData = 1;
        tick();
        clear = 1'b0; MemWrite = 1'b0;
        check_flags("clr", 0, 0, 0, 0);
        check("clr.wc", 32'(write_count), 0);
        check("clr.fa", fail_addr, 0);

        // wrong data at the pass address
        wr(100, 5);
        check_flags("baddata", 1, 0, 1, 0);
        check("baddata.fa", fail_addr, 100);
        check("baddata.fd", fail_data, 5);
        check("baddata.wc", 32'(write_count), 1);
        wr(100, 7);
        check_flags("fail.sticky", 1, 0, 1, 0);
        check("fail.sticky.fa", fail_addr, 100);
        check("fail.sticky.fd", fail_data, 5);
        check("fail.sticky.wc", 32'(write_count), 1);

        do_clear();
        check("clr2.fd", fail_data, 0);
        wr(200, 3);
        check_flags("illegal", 1, 0, 1, 0);
        check("illegal.fa", fail_addr, 200);
        check("illegal.fd", fail_data, 3);
        check("illegal.wc", 32'(write_count), 1);

        // timeout boundary: 39 idle edges stay RUN, edge 40 expires
        do_clear();
        repeat (39) tick();
        check_flags("to39", 0, 0, 0, 0);
        tick();
        check_flags("to40", 1, 0, 0, 1);
        tick();
        check_flags("to.sticky", 1, 0, 0, 1);

        do_clear();
        repeat (39) tick();
        wr(100, 7);
        check_flags("pass40", 1, 1, 0, 0);

        do_clear();
        repeat (39) tick();
        wr(5, 9);
        check_flags("fail40", 1, 0, 1, 0);
        check("fail40.fa", fail_addr, 5);

        // write counter saturation on the 2-bit copy
        do_clear();
        repeat (3) wr(96, 0);
        check("sat3.s_wc", 32'(s_write_count), 3);
        check("sat3.wc", 32'(write_count), 3);
        wr(96, 0);
        check("sat4.s_wc", 32'(s_write_count), 3);
        check("sat4.wc", 32'(write_count), 4);
        check("sat4.s_done", 32'(s_done), 0);

        // asynchronous reset mid-RUN
        reset = 1'b0;
        #1;
        check_flags("arst.run", 0, 0, 0, 0);
        check("arst.run.wc", 32'(write_count), 0);
        #1;
        reset = 1'b1;
        tick();

        // reset after a verdict discards it, then counting restarts
        wr(7, 7);
        check_flags("pre.arst", 1, 0, 1, 0);
        reset = 1'b0;
        #1;
        check_flags("arst.verdict", 0, 0, 0, 0);
        check("arst.verdict.fa", fail_addr, 0);
        check("arst.verdict.fd", fail_data, 0);
        #1;
        reset = 1'b1;
        repeat (39) tick();
        check_flags("rst.to39", 0, 0, 0, 0);
        tick();
        check_flags("rst.to40", 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
